// File: rtl/rom3_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// rom3_fetch_ctrl_if
// Bundles the signals of rom3_fetch_ctrl: the job command from the layer
// scheduler, the read port towards ROM3_handler and the output word stream.
//
// Signals
//   start, bank_sel, base_addr, num_words : job command (scheduler -> ctrl)
//   busy, done, err                       : job status   (ctrl -> scheduler)
//   rom_ena, rom_s, rom_addr              : ROM read     (ctrl -> handler)
//   rom_data                              : ROM word     (handler -> ctrl)
//   out_data, out_valid                   : word stream  (ctrl -> compute array)
//   out_ready                             : stream accept (compute array -> ctrl)
//
// Modports
//   master : the fetch controller itself
//   slave  : everything around it (scheduler, handler, consumer)
// -----------------------------------------------------------------------------
interface rom3_fetch_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 256
);
   logic              start;
   logic [3:0]        bank_sel;
   logic [ADDR_W-1:0] base_addr;
   logic [15:0]       num_words;
   logic              busy;
   logic              done;
   logic              err;
   logic              rom_ena;
   logic [3:0]        rom_s;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      input  start, bank_sel, base_addr, num_words, rom_data, out_ready,
      output busy, done, err, rom_ena, rom_s, rom_addr, out_data, out_valid
   );

   modport slave (
      output start, bank_sel, base_addr, num_words, rom_data, out_ready,
      input  busy, done, err, rom_ena, rom_s, rom_addr, out_data, out_valid
   );
endinterface

// File: rtl/rom3_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// rom3_fetch_ctrl
// Read sequencer for the ROM3 weight banks. A start command launches a burst
// of consecutive word reads from one bank; returned words are buffered in a
// small FIFO and streamed out over valid/ready with backpressure. Bank select
// and read enable are held for the whole job so no in-flight word is lost.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rom3_fetch_ctrl_if.master (command, status, ROM port, stream)
//
// Parameters
//   ADDR_W     : ROM address width
//   DATA_W     : word width
//   RD_LAT     : ROM read latency, issue to data valid (1..4)
//   FIFO_DEPTH : output buffer depth; >= RD_LAT+2 for one word per cycle
// -----------------------------------------------------------------------------
module rom3_fetch_ctrl #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 256,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   rom3_fetch_ctrl_if.master bus
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t            state;
   logic [15:0]       num_l;
   logic [15:0]       issued;
   logic [ADDR_W-1:0] addr_r;
   logic [3:0]        s_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;
   logic              ena_r;

   // One bit per outstanding read; the top bit marks rom_data valid this cycle.
   logic [RD_LAT-1:0] rd_vld_p;
   logic [IW-1:0]     inflight;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic issue;
   logic last_issue;
   logic push;
   logic pop;
   logic drained;
   logic bank_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + IW'(rd_vld_p[i]);
      end
   end

   assign bank_ok = (bus.bank_sel == 4'd1) || (bus.bank_sel == 4'd2);
   assign push    = rd_vld_p[RD_LAT-1];
   assign pop     = (count != '0) && bus.out_ready;

   // Credit check uses the occupancy before this cycle's pop, so a slot is
   // only reused once the pop has actually happened.
   assign issue      = (state == RUN) && (issued != num_l) &&
                       ((int'(inflight) + int'(count)) < FIFO_DEPTH);
   assign last_issue = issue && ((issued + 16'd1) == num_l);

   // Nothing left in flight and the final buffered word leaves this cycle.
   assign drained = (inflight == '0) &&
                    ((count == '0) || ((count == CW'(1)) && pop));

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         num_l    <= '0;
         issued   <= '0;
         addr_r   <= '0;
         s_r      <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         ena_r    <= 1'b0;
         rd_vld_p <= '0;
      end else begin
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         rd_vld_p <= (rd_vld_p << 1) | RD_LAT'(issue);
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  if ((bus.num_words == 16'd0) || !bank_ok) begin
                     state  <= FIN;
                     done_r <= 1'b1;
                     err_r  <= !bank_ok;
                  end else begin
                     state  <= RUN;
                     num_l  <= bus.num_words;
                     issued <= '0;
                     addr_r <= bus.base_addr;
                     s_r    <= bus.bank_sel;
                     busy_r <= 1'b1;
                     ena_r  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  issued <= issued + 16'd1;
                  addr_r <= addr_r + ADDR_W'(1);
               end
               if (last_issue) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // ena and bank stay up until the last word is in the FIFO.
               if (drained) begin
                  state  <= FIN;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  ena_r  <= 1'b0;
                  s_r    <= '0;
                  addr_r <= '0;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.rom_data;
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.rom_ena   = ena_r;
   assign bus.rom_s     = s_r;
   assign bus.rom_addr  = addr_r;
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_rom3_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rom3_fetch_ctrl
// Self-checking bench for rom3_fetch_ctrl. A behavioural ROM answers reads with
// a word derived from bank and 15-bit address; expected streams come from the
// job parameters alone (word i = ROM[bank][(base+i) mod 2^15]).
// -----------------------------------------------------------------------------
module tb_rom3_fetch_ctrl;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 256;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;

   logic clk;
   logic rst_n;

   rom3_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   rom3_fetch_ctrl #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RD_LAT    (RD_LAT),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ROM contents: every 32-bit lane carries bank and word address.
   function automatic logic [DATA_W-1:0] word_of(input logic [3:0] s, input logic [14:0] a);
      logic [31:0] lane;
      lane = {s, 1'b0, a, 12'hA5C};
      return {8{lane}};
   endfunction

   function automatic logic [DATA_W-1:0] exp_word(input logic [3:0] bank, input logic [15:0] base, input int i);
      int a;
      a = ((int'(base) + i) % 65536) % 32768;
      return word_of(bank, 15'(a));
   endfunction

   // Registered ROM with RD_LAT cycles of latency, output frozen while ena=0.
   logic [DATA_W-1:0] rom_pipe [RD_LAT];
   always @(posedge clk) begin
      if (bus.rom_ena) begin
         rom_pipe[0] <= word_of(bus.rom_s, bus.rom_addr[14:0]);
         for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
      end
   end
   assign bus.rom_data = rom_pipe[RD_LAT-1];

   // Observations of the last job run by run_job
   logic [DATA_W-1:0] got[$];
   logic [15:0]       addr_log [64];
   int   done_rel, first_vld_rel, last_hs_rel;
   int   busy_bad, ena_bad, rs_bad, stable_bad, err_other;
   logic err_at_done;

   // Drives one job (start in relative cycle 0) and observes it until done.
   // rmode: 0 ready always, 1 ready on even cycles, 2 ready random 3/4.
   task automatic run_job(input logic [3:0] bank, input logic [15:0] base, input int n,
                          input int rmode, input int poke_rel, input int max_cyc);
      int rel;
      int outstanding;
      logic legal, is_done, v, rdy, prev_stall;
      logic [DATA_W-1:0] d, prev_d;
      got.delete();
      done_rel = -1; first_vld_rel = -1; last_hs_rel = -1;
      busy_bad = 0; ena_bad = 0; rs_bad = 0; stable_bad = 0; err_other = 0;
      err_at_done = 1'b0;
      prev_stall = 1'b0; prev_d = '0;
      legal = ((bank == 4'd1) || (bank == 4'd2)) && (n != 0);
      @(negedge clk);
      bus.start = 1'b1; bus.bank_sel = bank; bus.base_addr = base;
      bus.num_words = 16'(n); bus.out_ready = 1'b1;
      rel = 0;
      while (done_rel < 0 && rel < max_cyc) begin
         @(negedge clk);
         rel++;
         if (rel == poke_rel) begin
            bus.start = 1'b1; bus.bank_sel = 4'd2; bus.base_addr = 16'h0500; bus.num_words = 16'd3;
         end else begin
            bus.start = 1'b0;
         end
         if (rel < 64) addr_log[rel] = bus.rom_addr;
         v = bus.out_valid; d = bus.out_data;
         if (bus.done === 1'b1) begin
            done_rel = rel; err_at_done = bus.err;
         end else if (bus.err !== 1'b0) begin
            err_other++;
         end
         is_done = (done_rel == rel);
         if (bus.busy !== (legal && !is_done)) busy_bad++;
         if (bus.rom_ena !== (legal && !is_done)) ena_bad++;
         if (bus.rom_s !== ((legal && !is_done) ? bank : 4'd0)) rs_bad++;
         if (prev_stall && (v !== 1'b1 || d !== prev_d)) stable_bad++;
         if (legal && !is_done) begin
            // rom_addr - base is the number of reads issued so far.
            outstanding = int'(16'(bus.rom_addr - base)) - got.size();
            n_checks++;
            if (outstanding > FIFO_DEPTH || outstanding < 0) begin
               n_fail++;
               $display("FAIL buffer_bound: outstanding words %0d, limit %0d", outstanding, FIFO_DEPTH);
               $fatal(1, "buffer overflow");
            end
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (rel % 2 == 0);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         bus.out_ready = rdy;
         if (v === 1'b1 && first_vld_rel < 0) first_vld_rel = rel;
         if (v === 1'b1 && rdy) begin
            got.push_back(d);
            last_hs_rel = rel;
         end
         prev_stall = (v === 1'b1) && !rdy;
         prev_d = d;
      end
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      bus.start = 1'b0; bus.bank_sel = 4'd0; bus.base_addr = '0; bus.num_words = '0;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if ({bus.busy, bus.done, bus.err, bus.rom_ena, bus.out_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy/done/err/ena/valid=%b, expected 00000",
                  {bus.busy, bus.done, bus.err, bus.rom_ena, bus.out_valid});
      end
      n_checks++;
      if (bus.rom_s !== 4'd0 || bus.rom_addr !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_rom: rom_s=%0d rom_addr=%h, expected 0 0000", bus.rom_s, bus.rom_addr);
      end
      n_checks++;
      if (bus.out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_data: out_data=%h, expected 0", bus.out_data);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      run_job(4'd1, 16'h0100, 8, 0, -1, 200);
      n_checks++;
      if (done_rel !== 12) begin n_fail++; $display("FAIL basic_done: done at T+%0d, expected T+12", done_rel); end
      n_checks++;
      if (first_vld_rel !== 4) begin n_fail++; $display("FAIL basic_first_valid: T+%0d, expected T+4", first_vld_rel); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (addr_log[i+1] !== 16'(16'h0100 + i)) begin
            n_fail++;
            $display("FAIL basic_addr[%0d]: rom_addr=%h, expected %h", i, addr_log[i+1], 16'(16'h0100 + i));
         end
      end
      n_checks++;
      if (got.size() !== 8) begin
         n_fail++; $display("FAIL basic_count: %0d words, expected 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got[i] !== exp_word(4'd1, 16'h0100, i)) begin
               n_fail++; $display("FAIL basic_word[%0d]: got %h expected %h", i, got[i], exp_word(4'd1, 16'h0100, i));
            end
         end
      end
      n_checks++;
      if (rs_bad + busy_bad + ena_bad + err_other !== 0 || err_at_done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_ctrl: rom_s/busy/ena/err faults %0d/%0d/%0d/%0d err_at_done=%b, expected 0",
                  rs_bad, busy_bad, ena_bad, err_other, err_at_done);
      end
   endtask

   task automatic test_backpressure;
      run_job(4'd2, 16'h0000, 16, 1, -1, 300);
      n_checks++;
      if (got.size() !== 16) begin
         n_fail++; $display("FAIL bp_count: %0d words, expected 16", got.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[i] !== exp_word(4'd2, 16'h0000, i)) begin
               n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got[i], exp_word(4'd2, 16'h0000, i));
            end
         end
      end
      n_checks++;
      if (stable_bad !== 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stall cycles, expected 0", stable_bad); end
      n_checks++;
      if (done_rel !== last_hs_rel + 1) begin
         n_fail++; $display("FAIL bp_done: done at T+%0d, expected T+%0d", done_rel, last_hs_rel + 1);
      end
      n_checks++;
      if (rs_bad + busy_bad + ena_bad !== 0) begin
         n_fail++; $display("FAIL bp_ctrl: rom_s/busy/ena faults %0d/%0d/%0d, expected 0", rs_bad, busy_bad, ena_bad);
      end
   endtask

   task automatic test_wrap;
      logic [15:0] exp_a [4];
      exp_a[0] = 16'h7FFE; exp_a[1] = 16'h7FFF; exp_a[2] = 16'h8000; exp_a[3] = 16'h8001;
      run_job(4'd1, 16'h7FFE, 4, 0, -1, 200);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (addr_log[i+1] !== exp_a[i]) begin
            n_fail++; $display("FAIL wrap_addr[%0d]: rom_addr=%h, expected %h", i, addr_log[i+1], exp_a[i]);
         end
      end
      n_checks++;
      if (got.size() !== 4) begin
         n_fail++; $display("FAIL wrap_count: %0d words, expected 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[i] !== exp_word(4'd1, 16'h7FFE, i)) begin
               n_fail++; $display("FAIL wrap_word[%0d]: got %h expected %h", i, got[i], exp_word(4'd1, 16'h7FFE, i));
            end
         end
      end
      n_checks++;
      if (done_rel !== 8 || err_at_done !== 1'b0) begin
         n_fail++; $display("FAIL wrap_done: done at T+%0d err=%b, expected T+8 err=0", done_rel, err_at_done);
      end
   endtask

   task automatic test_zero_and_illegal;
      run_job(4'd1, 16'h0100, 0, 0, -1, 20);
      n_checks++;
      if (done_rel !== 1 || err_at_done !== 1'b0) begin
         n_fail++; $display("FAIL zero_done: done at T+%0d err=%b, expected T+1 err=0", done_rel, err_at_done);
      end
      n_checks++;
      if (ena_bad + busy_bad + got.size() !== 0) begin
         n_fail++; $display("FAIL zero_idle: ena/busy faults %0d/%0d words %0d, expected 0", ena_bad, busy_bad, got.size());
      end
      run_job(4'd3, 16'h0100, 5, 0, -1, 20);
      n_checks++;
      if (done_rel !== 1 || err_at_done !== 1'b1) begin
         n_fail++; $display("FAIL illegal_done: done at T+%0d err=%b, expected T+1 err=1", done_rel, err_at_done);
      end
      n_checks++;
      if (ena_bad + busy_bad + rs_bad + got.size() !== 0) begin
         n_fail++; $display("FAIL illegal_idle: ena/busy/rom_s faults %0d/%0d/%0d words %0d, expected 0",
                            ena_bad, busy_bad, rs_bad, got.size());
      end
   endtask

   task automatic test_start_ignored;
      run_job(4'd1, 16'h0300, 8, 0, 3, 200);
      n_checks++;
      if (done_rel !== 12) begin n_fail++; $display("FAIL ignore_done: done at T+%0d, expected T+12", done_rel); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (addr_log[i+1] !== 16'(16'h0300 + i)) begin
            n_fail++; $display("FAIL ignore_addr[%0d]: rom_addr=%h, expected %h", i, addr_log[i+1], 16'(16'h0300 + i));
         end
      end
      n_checks++;
      if (got.size() !== 8) begin
         n_fail++; $display("FAIL ignore_count: %0d words, expected 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got[i] !== exp_word(4'd1, 16'h0300, i)) begin
               n_fail++; $display("FAIL ignore_word[%0d]: got %h expected %h", i, got[i], exp_word(4'd1, 16'h0300, i));
            end
         end
      end
      n_checks++;
      if (rs_bad !== 0) begin n_fail++; $display("FAIL ignore_bank: %0d rom_s faults, expected 0", rs_bad); end
   endtask

   task automatic test_reset_mid_job;
      int hs;
      int dones;
      int busies;
      @(negedge clk);
      bus.start = 1'b1; bus.bank_sel = 4'd2; bus.base_addr = 16'h0200; bus.num_words = 16'd10;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      hs = 0;
      for (int k = 0; k < 40 && hs < 3; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1 && bus.out_ready) hs++;
      end
      n_checks++;
      if (hs !== 3) begin n_fail++; $display("FAIL midrst_progress: %0d words seen, expected 3", hs); end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.err, bus.rom_ena, bus.out_valid} !== 5'b0 ||
          bus.rom_s !== 4'd0 || bus.rom_addr !== 16'd0 || bus.out_data !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: busy/done/err/ena/valid=%b rom_s=%0d rom_addr=%h, expected all 0",
                  {bus.busy, bus.done, bus.err, bus.rom_ena, bus.out_valid}, bus.rom_s, bus.rom_addr);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      dones = 0; busies = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done !== 1'b0) dones++;
         if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) busies++;
      end
      n_checks++;
      if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: %0d done cycles, expected 0", dones); end
      n_checks++;
      if (busies !== 0) begin n_fail++; $display("FAIL midrst_quiet: %0d busy/valid cycles, expected 0", busies); end
      run_job(4'd2, 16'h0040, 6, 0, -1, 200);
      n_checks++;
      if (done_rel !== 10) begin n_fail++; $display("FAIL midrst_rerun_done: done at T+%0d, expected T+10", done_rel); end
      n_checks++;
      if (got.size() !== 6) begin
         n_fail++; $display("FAIL midrst_rerun_count: %0d words, expected 6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== exp_word(4'd2, 16'h0040, i)) begin
               n_fail++; $display("FAIL midrst_rerun_word[%0d]: got %h expected %h", i, got[i], exp_word(4'd2, 16'h0040, i));
            end
         end
      end
   endtask

   task automatic test_random;
      logic [3:0]  bank;
      logic [15:0] base;
      int          n;
      for (int j = 0; j < 8; j++) begin
         bank = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
         base = 16'($urandom);
         if (j == 0) base = 16'hFFFC;
         n = $urandom_range(1, 24);
         run_job(bank, base, n, 2, -1, 400);
         n_checks++;
         if (got.size() !== n) begin
            n_fail++; $display("FAIL rand%0d_count: %0d words, expected %0d", j, got.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               n_checks++;
               if (got[i] !== exp_word(bank, base, i)) begin
                  n_fail++; $display("FAIL rand%0d_word[%0d]: got %h expected %h", j, i, got[i], exp_word(bank, base, i));
               end
            end
         end
         n_checks++;
         if (done_rel !== last_hs_rel + 1) begin
            n_fail++; $display("FAIL rand%0d_done: done at T+%0d, expected T+%0d", j, done_rel, last_hs_rel + 1);
         end
         n_checks++;
         if (stable_bad + rs_bad + busy_bad + ena_bad + err_other !== 0) begin
            n_fail++;
            $display("FAIL rand%0d_ctrl: stable/rom_s/busy/ena/err faults %0d/%0d/%0d/%0d/%0d, expected 0",
                     j, stable_bad, rs_bad, busy_bad, ena_bad, err_other);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_and_illegal();
      test_start_ignored();
      test_reset_mid_job();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before end of test");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rom3_fetch_ctrl.md
# rom3_fetch_ctrl

Read sequencer for the ROM3 weight-bank handler (two 256-bit banks, selected by `s` = 1 or 2, 15-bit word address, registered block-ROM read). On a start command it issues a burst of consecutive word reads from one bank and holds bank select steady until every word has returned. It buffers returned words in a small FIFO and streams them to the compute array over a valid/ready interface with backpressure. It sits between the layer scheduler and `ROM3_handler` and is the only driver of its `ena`, `s` and `address` inputs.

## Interface
- `ADDR_W`, 16: ROM address width driven to the handler.
- `DATA_W`, 256: word width.
- `RD_LAT`, 2: ROM read latency in cycles, issue to data valid; legal range 1..4.
- `FIFO_DEPTH`, 4: output buffer depth in words; must be ≥ `RD_LAT`+2 for 1 word/cycle throughput.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled only in IDLE.
- `bank_sel` in 4: bank for the job; legal values are 1 and 2.
- `base_addr` in ADDR_W: first word address.
- `num_words` in 16: word count; 0 is legal.
- `busy` out 1: high from accepted start until `done`, excluding the `done` cycle.
- `done` out 1: one-cycle pulse at job end.
- `err` out 1: one-cycle pulse coincident with `done` when `bank_sel` is illegal.
- `rom_ena` out 1: to handler `ena`.
- `rom_s` out 4: to handler `s`.
- `rom_addr` out ADDR_W: to handler `address`.
- `rom_data` in DATA_W: from handler `data`.
- `out_data` out DATA_W: FIFO head.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accept.

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE → RUN when `start`=1. Latch `bank_sel`, `base_addr` and `num_words`, and clear the issue and return counters.
- IDLE → FIN when `start`=1 and either `num_words`=0 or `bank_sel`∉{1,2}. No reads are issued. For the illegal bank, assert `err` in FIN.
- RUN: issue a read in a cycle when remaining > 0 and inflight + fifo_count < `FIFO_DEPTH`.
  - fifo_count is the value before any pop in the same cycle, so the check is conservative.
  - Issue means `rom_addr` = base + issued and the issued count increments.
  - `rom_addr` arithmetic is mod 2^ADDR_W. The handler ignores bit 15, so the effective wrap is at 0x7FFF → 0x0000. This is not an error.
- RUN → DRAIN in the cycle after the last issue.
- DRAIN → FIN when inflight = 0, the FIFO is empty and the last word has been handshaken.
- FIN: `done`=1 for one cycle, then → IDLE. `start` is ignored in FIN.
- Return tracking uses a valid shift register `RD_LAT` deep. The tail set means `rom_data` is valid this cycle, and the word is pushed into the FIFO at this cycle's edge. Inflight is the number of set bits.
- FIFO overflow cannot occur by construction. The bench must flag a push when the FIFO is full as a fatal error.
- `rom_ena` = 1 in RUN and DRAIN, 0 otherwise. It is never dropped while a read is in flight, because `ena` gates the ROM output register.
- `rom_s` = latched bank in RUN and DRAIN, 0 in IDLE and FIN. `rom_s` must not change until the last word has been captured.
- `start` while busy is ignored; the job is not queued.
- Reset mid-job: all state is cleared immediately, the FIFO is emptied and in-flight words are discarded. No `done` is produced.

## Timing
- Reset values: `busy`, `done`, `err`, `rom_ena`, `out_valid` = 0; `rom_s` = 0, `rom_addr` = 0, `out_data` = 0.
- Start accepted in cycle T → first issue in T+1 (`rom_addr` = base) → `rom_data` valid in T+1+`RD_LAT` → `out_valid` in T+2+`RD_LAT` (T+4 at defaults).
- With `out_ready` held at 1, words issue and are delivered one per cycle with no bubbles.
- `out_valid`=1 and `out_ready`=0: `out_data` is held stable. Issue stalls once inflight + count reaches `FIFO_DEPTH`.
- `done` is asserted the cycle after the last handshake. `busy` falls in the same cycle as `done`, and a new `start` is accepted the cycle after `done`.
- Zero-length or illegal-bank job: `done` at T+1; `busy` is never asserted.

## Test plan
- base=0x0100, n=8, bank 1, `out_ready`=1 → `rom_addr` 0x0100..0x0107 in T+1..T+8, 8 words in order with first `out_valid` at T+4, `done` at T+12, `rom_s`=1 throughout.
- base=0x0000, n=16, bank 2, `out_ready` toggling 1/0 each cycle → all 16 words delivered in order, never more than 4 buffered (inflight + count), `out_data` stable while stalled.
- base=0x7FFE, n=4, bank 1 → `rom_addr` 0x7FFE, 0x7FFF, 0x8000, 0x8001 are issued, fetching ROM words 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- n=0 → `done` at T+1, `rom_ena` stays 0. `bank_sel`=3 with n=5 → `done` and `err` at T+1, no reads issued.
- `rst_n` low for 1 cycle mid-burst (after 3 of 10 words delivered) → all outputs 0 asynchronously, no `done`. A new job after release runs normally.
- `start` pulsed during RUN with different params → ignored; the original job completes unchanged.
